// File: rtl/fifo_controller_pkg.sv
// Shared definitions for the FIFO controller: state enumeration, state
// encodings and the default pointer width.
package fifo_controller_pkg;

  // Default pointer/address width (minus one) of the downstream pointer stage.
  localparam int DEFAULT_ADD_WIDTH = 4;

  // State encodings.
  localparam int          STATE_W        = 3;
  localparam logic [2:0]  ENC_INIT       = 3'd0;
  localparam logic [2:0]  ENC_IDLE       = 3'd1;
  localparam logic [2:0]  ENC_WR_SETUP   = 3'd2;
  localparam logic [2:0]  ENC_WR_MEM     = 3'd3;
  localparam logic [2:0]  ENC_RD_SETUP   = 3'd4;
  localparam logic [2:0]  ENC_RD_MEM     = 3'd5;
  localparam logic [2:0]  ENC_RD_DONE    = 3'd6;

  typedef enum logic [STATE_W-1:0] {
    INIT     = ENC_INIT,
    IDLE     = ENC_IDLE,
    WR_SETUP = ENC_WR_SETUP,
    WR_MEM   = ENC_WR_MEM,
    RD_SETUP = ENC_RD_SETUP,
    RD_MEM   = ENC_RD_MEM,
    RD_DONE  = ENC_RD_DONE
  } state_e;

endpackage

// File: rtl/fifo_occupancy.sv
// Saturating occupancy counter with registered full/empty flags.
// full_o/empty_o are derived from the next count value and registered, so
// they always agree with count and never depend on pointer comparators.
module fifo_occupancy
  import fifo_controller_pkg::*;
#(
  parameter int CW       = DEFAULT_ADD_WIDTH + 1,
  parameter int CAPACITY = 2**CW - 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [CW-1:0] CAP_W  = CW'(CAPACITY);
  localparam logic [CW-1:0] ONE_W  = CW'(1);
  localparam logic [CW-1:0] ZERO_W = CW'(0);

  logic [CW-1:0] count_d, count_q;
  logic          full_d, full_q;
  logic          empty_d, empty_q;

  // Next count: increment/decrement with saturation at both ends.
  always_comb begin
    count_d = count_q;
    if (inc && !dec && (count_q != CAP_W)) begin
      count_d = count_q + ONE_W;
    end else if (dec && !inc && (count_q != ZERO_W)) begin
      count_d = count_q - ONE_W;
    end else begin
      count_d = count_q;
    end
    full_d  = (count_d == CAP_W);
    empty_d = (count_d == ZERO_W);
  end

  // Occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= ZERO_W;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign count   = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/fifo_controller.sv
// FIFO controller: FSM sequencing the pointer stage and RAM strobes, with an
// alternating write/read arbiter and an occupancy sub-module.
// Optional feature macro: FIFO_CTRL_ERR_EN -- when defined, a write request on
// a full FIFO or a read request on an empty FIFO raises wr_err / rd_err for
// one cycle; otherwise such requests are silently held off and the error
// outputs stay 0.
module fifo_controller
  import fifo_controller_pkg::*;
#(
  parameter int ADD_WIDTH = DEFAULT_ADD_WIDTH,
  parameter int CAPACITY  = 2**(ADD_WIDTH+1) - 1
) (
  input  logic               clk,
  input  logic               Clear,
  input  logic               wr_req,
  input  logic               rd_req,
  output logic               sel,
  output logic               EnableP,
  output logic               ClearP,
  output logic               ram_we,
  output logic               ram_re,
  output logic               wr_ack,
  output logic               rd_ack,
  output logic               wr_err,
  output logic               rd_err,
  output logic [ADD_WIDTH:0] count,
  output logic               full_o,
  output logic               empty_o,
  output logic               busy
);

  state_e state_d, state_q;
  logic   init_arm_d, init_arm_q;   // keeps INIT for one full clock after Clear drops
  logic   last_wr_d, last_wr_q;     // 1: last contended grant went to the writer
  logic   sel_d, sel_q;
  logic   enp_d, enp_q;
  logic   clrp_d, clrp_q;
  logic   ram_we_d, ram_we_q;
  logic   ram_re_d, ram_re_q;
  logic   wr_ack_d, wr_ack_q;
  logic   rd_ack_d, rd_ack_q;
  logic   wr_err_d, wr_err_q;
  logic   rd_err_d, rd_err_q;
  logic   busy_d, busy_q;

  logic   full_s, empty_s;
  logic   wr_grant_s, rd_grant_s;
  logic   inc_s, dec_s;

  // Count moves when the memory access state completes, so an abort by Clear
  // inside WR_MEM/RD_MEM leaves no count change behind.
  assign inc_s = (state_q == WR_MEM);
  assign dec_s = (state_q == RD_MEM);

  fifo_occupancy #(
    .CW       (ADD_WIDTH + 1),
    .CAPACITY (CAPACITY)
  ) u_occupancy (
    .clk     (clk),
    .clr     (Clear),
    .inc     (inc_s),
    .dec     (dec_s),
    .count   (count),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  assign wr_grant_s = wr_req && !full_s;
  assign rd_grant_s = rd_req && !empty_s;

  // Next-state logic and arbitration; the last-served flag only moves when
  // both sides were grantable, so uncontended traffic does not bias it.
  always_comb begin
    state_d    = state_q;
    init_arm_d = 1'b0;
    last_wr_d  = last_wr_q;
    wr_err_d   = 1'b0;
    rd_err_d   = 1'b0;
    case (state_q)
      INIT: begin
        if (init_arm_q) begin
          state_d = INIT;
        end else begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (wr_grant_s && rd_grant_s) begin
          if (last_wr_q) begin
            state_d   = RD_SETUP;
            last_wr_d = 1'b0;
          end else begin
            state_d   = WR_SETUP;
            last_wr_d = 1'b1;
          end
        end else if (wr_grant_s) begin
          state_d = WR_SETUP;
        end else if (rd_grant_s) begin
          state_d = RD_SETUP;
        end else begin
          state_d = IDLE;
`ifdef FIFO_CTRL_ERR_EN
          wr_err_d = wr_req && full_s;
          rd_err_d = rd_req && empty_s;
`else
          wr_err_d = 1'b0;
          rd_err_d = 1'b0;
`endif
        end
      end
      WR_SETUP: state_d = WR_MEM;
      WR_MEM:   state_d = IDLE;
      RD_SETUP: state_d = RD_MEM;
      RD_MEM:   state_d = RD_DONE;
      RD_DONE:  state_d = IDLE;
      default:  state_d = INIT;
    endcase
  end

  // Output decode from the next state so every output is a register that
  // lines up with the state it belongs to; sel holds outside access states.
  always_comb begin
    sel_d    = sel_q;
    enp_d    = 1'b0;
    clrp_d   = 1'b1;
    ram_we_d = 1'b0;
    ram_re_d = 1'b0;
    wr_ack_d = 1'b0;
    rd_ack_d = 1'b0;
    busy_d   = (state_d != IDLE);
    case (state_d)
      INIT: clrp_d = 1'b0;
      IDLE: clrp_d = 1'b1;
      WR_SETUP: begin
        sel_d = 1'b1;
        enp_d = 1'b1;
      end
      WR_MEM: begin
        sel_d    = 1'b1;
        ram_we_d = 1'b1;
        wr_ack_d = 1'b1;
      end
      RD_SETUP: begin
        sel_d = 1'b0;
        enp_d = 1'b1;
      end
      RD_MEM: begin
        sel_d    = 1'b0;
        ram_re_d = 1'b1;
      end
      RD_DONE: rd_ack_d = 1'b1;
      default: clrp_d = 1'b0;
    endcase
  end

  // State, arbiter flag and output registers; Clear forces the reset image.
  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      state_q    <= INIT;
      init_arm_q <= 1'b1;
      last_wr_q  <= 1'b0;
      sel_q      <= 1'b0;
      enp_q      <= 1'b0;
      clrp_q     <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_re_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      init_arm_q <= init_arm_d;
      last_wr_q  <= last_wr_d;
      sel_q      <= sel_d;
      enp_q      <= enp_d;
      clrp_q     <= clrp_d;
      ram_we_q   <= ram_we_d;
      ram_re_q   <= ram_re_d;
      wr_ack_q   <= wr_ack_d;
      rd_ack_q   <= rd_ack_d;
      wr_err_q   <= wr_err_d;
      rd_err_q   <= rd_err_d;
      busy_q     <= busy_d;
    end
  end

  assign sel     = sel_q;
  assign EnableP = enp_q;
  assign ClearP  = clrp_q;
  assign ram_we  = ram_we_q;
  assign ram_re  = ram_re_q;
  assign wr_ack  = wr_ack_q;
  assign rd_ack  = rd_ack_q;
  assign wr_err  = wr_err_q;
  assign rd_err  = rd_err_q;
  assign full_o  = full_s;
  assign empty_o = empty_s;
  assign busy    = busy_q;

endmodule

// File: tb/tb_fifo_controller.sv
// Self-checking bench for fifo_controller with a transaction-level model:
// occupancy as an integer, a contention-only alternation flag, and fixed
// per-cycle output patterns for each kind of request outcome.
module tb_fifo_controller;
  localparam int AW  = 4;
  localparam int CAP = 31;
`ifdef FIFO_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic Clear, wr_req, rd_req;
  logic sel, EnableP, ClearP, ram_we, ram_re, wr_ack, rd_ack, wr_err, rd_err;
  logic [AW:0] count;
  logic full_o, empty_o, busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int m_count   = 0;
  bit m_last_wr = 1'b0;

  fifo_controller #(.ADD_WIDTH(AW), .CAPACITY(CAP)) dut (
    .clk(clk), .Clear(Clear), .wr_req(wr_req), .rd_req(rd_req),
    .sel(sel), .EnableP(EnableP), .ClearP(ClearP), .ram_we(ram_we), .ram_re(ram_re),
    .wr_ack(wr_ack), .rd_ack(rd_ack), .wr_err(wr_err), .rd_err(rd_err),
    .count(count), .full_o(full_o), .empty_o(empty_o), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reset sequence with checks of the reset image and the INIT->IDLE handoff.
  task automatic test_reset();
    logic [9:0] got;
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0; Clear = 1'b1;
    #1;
    got = {ClearP, sel, EnableP, ram_we, ram_re, wr_ack, rd_ack, wr_err, rd_err, busy};
    total_cnt++; if (got !== 10'b0000000001) $display("FAIL reset_outputs: got %b expected %b", got, 10'b0000000001); else pass_cnt++;
    total_cnt++; if ({count, empty_o, full_o} !== {5'd0, 1'b1, 1'b0}) $display("FAIL reset_status: got count=%0d empty=%b full=%b expected 0/1/0", count, empty_o, full_o); else pass_cnt++;
    @(negedge clk);
    Clear = 1'b0;
    @(negedge clk);
    total_cnt++; if ({ClearP, busy} !== 2'b01) $display("FAIL init_cycle: got ClearP/busy=%b expected 01", {ClearP, busy}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({ClearP, busy, empty_o, count} !== {1'b1, 1'b0, 1'b1, 5'd0}) $display("FAIL idle_after_init: got ClearP=%b busy=%b empty=%b count=%0d expected 1/0/1/0", ClearP, busy, empty_o, count); else pass_cnt++;
    m_count   = 0;
    m_last_wr = 1'b0;
  endtask

  // One uncontended request held until ack/err (or a hold-off budget).
  task automatic run_op(input bit is_wr);
    bit granted;
    int last_c;
    logic [6:0] got, exp;
    granted = is_wr ? (m_count < CAP) : (m_count > 0);
    last_c  = granted ? (is_wr ? 2 : 3) : 1;
    wr_req = is_wr; rd_req = !is_wr;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      got = {EnableP, ram_we, ram_re, wr_ack, rd_ack, wr_err, rd_err};
      exp = 7'b0000000;
      if (granted) begin
        if (c == 1) exp = 7'b1000000;
        else if (c == 2) exp = is_wr ? 7'b0101000 : 7'b0010000;
        else if (c == 3 && !is_wr) exp = 7'b0000100;
        else exp = 7'b0000000;
      end else if (ERR_EN && c == 1) begin
        exp = is_wr ? 7'b0000010 : 7'b0000001;
      end else begin
        exp = 7'b0000000;
      end
      total_cnt++; if (got !== exp) $display("FAIL op_%s_cycle%0d: got %b expected %b (count model %0d)", is_wr ? "wr" : "rd", c, got, exp, m_count); else pass_cnt++;
      if (granted && c <= last_c && c <= 2) begin
        total_cnt++; if (sel !== is_wr) $display("FAIL op_sel_cycle%0d: got %b expected %b", c, sel, is_wr); else pass_cnt++;
      end
      if (wr_ack || rd_ack || wr_err || rd_err || c == 6) begin
        wr_req = 1'b0; rd_req = 1'b0;
      end
    end
    if (granted) m_count = is_wr ? m_count + 1 : m_count - 1;
    total_cnt++; if ({count, full_o, empty_o, busy} !== {5'(m_count), (m_count == CAP), (m_count == 0), 1'b0})
      $display("FAIL op_status: got count=%0d full=%b empty=%b busy=%b expected count=%0d", count, full_o, empty_o, busy, m_count); else pass_cnt++;
  endtask

  task automatic test_single_write();
    test_reset();
    run_op(1'b1);
    total_cnt++; if (count !== 5'd1) $display("FAIL single_write_count: got %0d expected 1", count); else pass_cnt++;
  endtask

  task automatic test_fill();
    test_reset();
    for (int i = 0; i < CAP; i++) run_op(1'b1);
    total_cnt++; if ({full_o, count} !== {1'b1, 5'd31}) $display("FAIL fill_full: got full=%b count=%0d expected 1/31", full_o, count); else pass_cnt++;
    run_op(1'b1);
    total_cnt++; if (count !== 5'd31) $display("FAIL overfill_count: got %0d expected 31", count); else pass_cnt++;
  endtask

  task automatic test_read_empty();
    test_reset();
    run_op(1'b0);
    run_op(1'b1);
    run_op(1'b0);
    total_cnt++; if ({empty_o, count} !== {1'b1, 5'd0}) $display("FAIL read_back_empty: got empty=%b count=%0d expected 1/0", empty_o, count); else pass_cnt++;
  endtask

  // Both requests held: grants must alternate, write first after reset.
  task automatic test_alternate();
    int n, cyc;
    bit pend, exp_w, gw, gr;
    test_reset();
    for (int i = 0; i < 5; i++) run_op(1'b1);
    wr_req = 1'b1; rd_req = 1'b1;
    n = 0; pend = 1'b0; cyc = 0;
    while ((n < 4 || pend) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        total_cnt++; if (count !== 5'(m_count)) $display("FAIL alt_count_%0d: got %0d expected %0d", n, count, m_count); else pass_cnt++;
        pend = 1'b0;
      end
      if (wr_ack || rd_ack) begin
        gw = (m_count < CAP); gr = (m_count > 0);
        if (gw && gr) begin exp_w = !m_last_wr; m_last_wr = exp_w; end
        else exp_w = gw;
        total_cnt++; if ({wr_ack, rd_ack} !== {exp_w, !exp_w}) $display("FAIL alt_grant_%0d: got wr_ack/rd_ack=%b expected %b", n, {wr_ack, rd_ack}, {exp_w, !exp_w}); else pass_cnt++;
        m_count = exp_w ? m_count + 1 : m_count - 1;
        pend = 1'b1;
        n++;
        if (n == 4) begin wr_req = 1'b0; rd_req = 1'b0; end
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    total_cnt++; if (n !== 4) $display("FAIL alt_timeout: got %0d grants expected 4", n); else pass_cnt++;
    repeat (4) @(negedge clk);
    total_cnt++; if ({busy, count} !== {1'b0, 5'd5}) $display("FAIL alt_final: got busy=%b count=%0d expected 0/5", busy, count); else pass_cnt++;
  endtask

  // Clear lands while the write access is in progress.
  task automatic test_clear_mid();
    logic [8:0] got;
    test_reset();
    run_op(1'b1);
    run_op(1'b1);
    wr_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if ({ram_we, wr_ack} !== 2'b11) $display("FAIL clr_pre_wrmem: got ram_we/wr_ack=%b expected 11", {ram_we, wr_ack}); else pass_cnt++;
    Clear = 1'b1;
    #1;
    got = {ClearP, sel, EnableP, ram_we, ram_re, wr_ack, rd_ack, empty_o, busy};
    total_cnt++; if (got !== 9'b000000011) $display("FAIL clr_immediate: got %b expected %b", got, 9'b000000011); else pass_cnt++;
    total_cnt++; if (count !== 5'd0) $display("FAIL clr_count: got %0d expected 0", count); else pass_cnt++;
    wr_req = 1'b0;
    @(negedge clk);
    Clear = 1'b0;
    @(negedge clk);
    total_cnt++; if ({ClearP, busy, wr_ack} !== 3'b010) $display("FAIL clr_init: got ClearP/busy/wr_ack=%b expected 010", {ClearP, busy, wr_ack}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({ClearP, busy, count} !== {1'b1, 1'b0, 5'd0}) $display("FAIL clr_idle: got ClearP=%b busy=%b count=%0d expected 1/0/0", ClearP, busy, count); else pass_cnt++;
    m_count = 0; m_last_wr = 1'b0;
  endtask

  // Random single requests with phase-biased direction to reach both ends.
  task automatic test_random();
    bit is_wr;
    test_reset();
    for (int i = 0; i < 150; i++) begin
      if (i < 50) is_wr = ($urandom_range(0, 99) < 80);
      else if (i < 100) is_wr = ($urandom_range(0, 99) < 20);
      else is_wr = ($urandom_range(0, 1) == 1);
      run_op(is_wr);
    end
  endtask

  initial begin
    Clear = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    test_reset();
    test_single_write();
    test_fill();
    test_read_empty();
    test_alternate();
    test_clear_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_controller.md
FIFO_CONTROLLER -- requirements
Module: fifo_controller

Interface
REQ-001 SHALL have parameter ADD_WIDTH, default 4; pointer/address width minus one, matching the downstream pointer stage.
REQ-002 SHALL have parameter CAPACITY, default 2**(ADD_WIDTH+1)-1 (31); maximum stored words.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port Clear, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have ports wr_req and rd_req, input, 1 each; user write and read requests, level, held until ack or err.
REQ-006 SHALL have ports sel (1=write, 0=read), EnableP and ClearP (active-low), output, 1 each; drive the pointer stage.
REQ-007 SHALL have ports ram_we and ram_re, output, 1 each; RAM write and read strobes.
REQ-008 SHALL have ports wr_ack, rd_ack, wr_err and rd_err, output, 1 each; one-cycle completion and error pulses.
REQ-009 SHALL have ports count ([ADD_WIDTH:0]), full_o, empty_o and busy, output; occupancy status.

Function
REQ-010 SHALL implement FSM states INIT, IDLE, WR_SETUP, WR_MEM, RD_SETUP, RD_MEM and RD_DONE.
REQ-011 INIT SHALL drive ClearP=0 for exactly one cycle, then go to IDLE.
REQ-012 IDLE SHALL go to WR_SETUP on a write grant, RD_SETUP on a read grant, and otherwise stay in IDLE.
REQ-013 Write grant SHALL require wr_req=1 and full_o=0.
REQ-014 Read grant SHALL require rd_req=1 and empty_o=0.
REQ-015 When both are grantable, arbitration SHALL alternate using a last-served flag; after reset, write wins first.
REQ-016 WR_SETUP SHALL drive sel=1 and EnableP=1 for one cycle, then go to WR_MEM.
REQ-017 WR_MEM SHALL drive sel=1, ram_we=1 and wr_ack=1, increment count, then go to IDLE.
REQ-018 RD_SETUP SHALL drive sel=0 and EnableP=1, then go to RD_MEM.
REQ-019 RD_MEM SHALL drive sel=0 and ram_re=1, decrement count, then go to RD_DONE.
REQ-020 RD_DONE SHALL pulse rd_ack=1 (RAM data valid), then go to IDLE.
REQ-021 Latency SHALL be: write req sampled in IDLE at cycle N gives wr_ack at N+2; read req at cycle N gives rd_ack at N+3.
REQ-022 Outside the stated states, EnableP, ram_we, ram_re and the acks SHALL be 0, and sel SHALL hold its last value.
REQ-023 full_o SHALL equal (count==CAPACITY) and empty_o SHALL equal (count==0); both registered-derived, never from the pointer's combinational flags.
REQ-024 count SHALL never exceed CAPACITY nor go below 0; no wrap-around is permitted.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 A request arriving while busy SHALL be held off until IDLE; it SHALL be neither lost nor double-served.
REQ-027 A request still high the cycle after its ack SHALL be treated as a new request.

Reset
REQ-028 Clear=1 SHALL immediately force: state INIT, ClearP=0, sel=0, EnableP=0, ram_we=0, ram_re=0, all acks and errs 0, count=0, empty_o=1, full_o=0, busy=1, last-served=read.
REQ-029 Clear asserted mid-operation SHALL abort with no ack and no count change; after deassertion, INIT then IDLE.

Configuration
REQ-030 With FIFO_CTRL_ERR_EN defined: in IDLE, wr_req with full_o=1 SHALL pulse wr_err for one cycle, and rd_req with empty_o=1 SHALL pulse rd_err for one cycle; no pointer activity and the state stays IDLE.
REQ-031 Without FIFO_CTRL_ERR_EN: such requests SHALL be silently held off, and wr_err and rd_err SHALL be constant 0.

Structure
REQ-032 A shared package SHALL hold the state enumeration typedef, the state encodings and the default ADD_WIDTH constant.
REQ-033 The occupancy counter with full/empty derivation SHALL be a sub-module named fifo_occupancy; the FSM and arbiter stay in fifo_controller.

Verification
REQ-034 Reset then idle: ClearP=0 for one cycle after Clear falls; then count=0, empty_o=1, busy=0.
REQ-035 Single write at cycle N: sel=1 and EnableP=1 at N+1; ram_we=1 and wr_ack=1 at N+2; count=1, empty_o=0.
REQ-036 Fill with 31 writes: full_o=1 and count=31; a 32nd wr_req gives wr_err pulse (with macro) or no ack (without); count stays 31.
REQ-037 Simultaneous wr_req and rd_req held with count=5: grants alternate W,R,W,R starting with write; count oscillates 6,5,6,5.
REQ-038 Read on empty: rd_req with count=0 gives no EnableP and rd_err pulse (with macro); then one write followed by one read gives rd_ack at 3 cycles.
REQ-039 Clear asserted during WR_MEM: outputs take reset values in the same cycle, no wr_ack, count=0, and INIT then follows.
